// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between N_REQ producers, the write arbiter and the fifo write side.
// Directions are named from the arbiter's point of view (master = arbiter).
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*DATA_W-1:0] i_data;
  logic                    i_fifo_full;
  logic [N_REQ-1:0]        o_gnt;
  logic [N_REQ-1:0]        o_ack;
  logic [ID_W-1:0]         o_grant_id;
  logic                    o_busy;
  logic [DATA_W-1:0]       o_fifo_din;
  logic                    o_fifo_wr_en;

  modport master (
    input  i_req, i_data, i_fifo_full,
    output o_gnt, o_ack, o_grant_id, o_busy, o_fifo_din, o_fifo_wr_en
  );

  modport slave (
    output i_req, i_data, i_fifo_full,
    input  o_gnt, o_ack, o_grant_id, o_busy, o_fifo_din, o_fifo_wr_en
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among N_REQ producers, bounded bursts.
// Grant is registered; ACK/WR_EN/DIN are combinational and gated by fifo Full and reset.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int              ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]      LAST_BEAT = 8'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [ID_W-1:0]   r_grant_id, w_grant_id_nxt;
  logic [ID_W-1:0]   r_pri, w_pri_nxt;
  logic              r_busy, w_busy_nxt;
  logic [7:0]        r_burst_cnt, w_burst_cnt_nxt;
  logic [ID_W-1:0]   w_win;
  logic              w_found;
  logic [N_REQ-1:0]  w_ack;
  logic              w_wr_en;
  logic              w_ack_g;
  logic              w_release;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  assign w_ack     = r_gnt & bus.i_req & {N_REQ{~bus.i_fifo_full & ~i_rst}};
  assign w_wr_en   = |w_ack;
  assign w_ack_g   = w_ack[r_grant_id];
  assign w_release = (w_ack_g && (r_burst_cnt == LAST_BEAT)) || !bus.i_req[r_grant_id];

  // First requester at or above the priority pointer, wrapping around.
  always_comb begin
    w_win   = r_pri;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && bus.i_req[wrap_idx(r_pri, k)]) begin
        w_win   = wrap_idx(r_pri, k);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_grant_id_nxt  = r_grant_id;
    w_pri_nxt       = r_pri;
    w_busy_nxt      = r_busy;
    w_burst_cnt_nxt = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt        = '0;
          w_gnt_nxt[w_win] = 1'b1;
          w_grant_id_nxt   = w_win;
          w_busy_nxt       = 1'b1;
          w_burst_cnt_nxt  = '0;
          w_state_nxt      = S_BURST;
        end
      end
      S_BURST: begin
        if (w_release) begin
          w_gnt_nxt       = '0;
          w_busy_nxt      = 1'b0;
          w_burst_cnt_nxt = '0;
          w_pri_nxt       = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
          w_state_nxt     = S_IDLE;
        end else if (w_ack_g) begin
          w_burst_cnt_nxt = r_burst_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_grant_id  <= '0;
      r_pri       <= '0;
      r_busy      <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_pri       <= w_pri_nxt;
      r_busy      <= w_busy_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  assign bus.o_gnt        = r_gnt;
  assign bus.o_ack        = w_ack;
  assign bus.o_grant_id   = r_grant_id;
  assign bus.o_busy       = r_busy;
  assign bus.o_fifo_wr_en = w_wr_en;
  assign bus.o_fifo_din   = w_wr_en ? bus.i_data[r_grant_id*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a 128-deep behavioural fifo and producer models.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_en = 1'b0;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(W), .ID_W(2)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]   fq[$];
  bit           en[N];
  int           limit[N];
  int           sent[N];
  logic [7:0]   base[N];
  int           n_chk = 0;
  int           n_err = 0;
  int           grants = 0;
  int           gid_log[$];
  logic [N-1:0] prev_gnt = '0;
  int           guard;
  int           bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bus.i_req[i]          = en[i] && (limit[i] == 0 || sent[i] < limit[i]);
      bus.i_data[i*W +: W]  = base[i] + 8'(sent[i]);
    end
    bus.i_fifo_full = (fq.size() >= DEPTH);
  endtask

  // One clock: sample the write path, advance fifo and producers, land on the next falling edge.
  task automatic step();
    logic         wr;
    logic [7:0]   din;
    logic [N-1:0] ack;
    logic         rd;
    #1;
    wr  = bus.o_fifo_wr_en;
    din = bus.o_fifo_din;
    ack = bus.o_ack;
    rd  = rd_en;
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) void'(fq.pop_front());
    if (wr && fq.size() < DEPTH) fq.push_back(din);
    for (int i = 0; i < N; i++) if (ack[i]) sent[i]++;
    drive_inputs();
    @(negedge clk);
    if (bus.o_gnt != '0 && prev_gnt == '0) begin
      grants++;
      gid_log.push_back(int'(bus.o_grant_id));
    end
    prev_gnt = bus.o_gnt;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    rd_en = 1'b0;
    fq.delete();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; limit[i] = 0; sent[i] = 0; base[i] = 8'h00;
    end
    drive_inputs();
    step();
    step();
    rst = 1'b0;
    grants = 0;
    gid_log.delete();
    prev_gnt = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1; limit[i] = 0; sent[i] = 0; base[i] = 8'h00;
    end
    drive_inputs();
    @(negedge clk);
    // Requests present while reset is held: nothing may be granted or written.
    step();
    step();
    chk("rst_gnt", 32'(bus.o_gnt), 32'h0);
    chk("rst_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
    chk("rst_busy", 32'(bus.o_busy), 32'h0);
    chk("rst_gid", 32'(bus.o_grant_id), 32'h0);

    // Test 1: single producer, back-to-back bursts until the fifo fills.
    do_reset();
    en[0] = 1'b1; base[0] = 8'h01;
    drive_inputs();
    #1;
    chk("t1_gnt_cycle_n", 32'(bus.o_gnt), 32'h0);
    step();
    chk("t1_gnt_n1", 32'(bus.o_gnt), 32'h1);
    chk("t1_busy", 32'(bus.o_busy), 32'h1);
    chk("t1_din1", 32'(bus.o_fifo_din), 32'h01);
    step();
    chk("t1_din2", 32'(bus.o_fifo_din), 32'h02);
    step();
    chk("t1_din3", 32'(bus.o_fifo_din), 32'h03);
    step();
    chk("t1_din4", 32'(bus.o_fifo_din), 32'h04);
    step();
    chk("t1_gap_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
    chk("t1_gap_gnt", 32'(bus.o_gnt), 32'h0);
    chk("t1_gap_busy", 32'(bus.o_busy), 32'h0);
    step();
    chk("t1_regrant", 32'(bus.o_gnt), 32'h1);
    chk("t1_din5", 32'(bus.o_fifo_din), 32'h05);
    guard = 0;
    while (fq.size() < DEPTH && guard < 600) begin
      step();
      guard++;
    end
    chk("t1_count", 32'(fq.size()), 32'd128);
    chk("t1_grants", 32'(grants), 32'd32);
    chk("t1_full", 32'(bus.i_fifo_full), 32'h1);
    bad = 0;
    for (int k = 0; k < fq.size(); k++) if (fq[k] != 8'(k + 1)) bad++;
    chk("t1_contents", 32'(bad), 32'd0);
    step();
    step();
    chk("t1_full_no_ack", 32'(bus.o_ack), 32'h0);

    // Test 2: all four requesting, round-robin order and fifo contents.
    do_reset();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1; base[i] = 8'(i * 16);
    end
    drive_inputs();
    guard = 0;
    while ((fq.size() < 16 || grants < 5) && guard < 200) begin
      step();
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", (k < gid_log.size()) ? 32'(gid_log[k]) : 32'hffff_ffff, 32'(k % 4));
    end
    for (int k = 0; k < 16; k++) begin
      chk("t2_word", (k < fq.size()) ? 32'(fq[k]) : 32'hffff_ffff, 32'((k / 4) * 16 + (k % 4)));
    end

    // Test 3: one free slot, stall on Full with grant held, resume after a read.
    do_reset();
    for (int k = 0; k < 127; k++) fq.push_back(8'hee);
    en[2] = 1'b1; base[2] = 8'h80;
    drive_inputs();
    step();
    chk("t3_gnt", 32'(bus.o_gnt), 32'h4);
    chk("t3_ack_first", 32'(bus.o_ack), 32'h4);
    chk("t3_din_first", 32'(bus.o_fifo_din), 32'h80);
    step();
    chk("t3_count_full", 32'(fq.size()), 32'd128);
    chk("t3_ack_stall", 32'(bus.o_ack), 32'h0);
    chk("t3_wr_en_stall", 32'(bus.o_fifo_wr_en), 32'h0);
    chk("t3_burst_cnt", 32'(dut.r_burst_cnt), 32'd1);
    step();
    step();
    chk("t3_gnt_held", 32'(bus.o_gnt), 32'h4);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t3_ack_resume", 32'(bus.o_ack), 32'h4);
    chk("t3_din_resume", 32'(bus.o_fifo_din), 32'h81);

    // Test 4: producer 1 drops after two words, producer 3 follows.
    do_reset();
    en[1] = 1'b1; limit[1] = 2; base[1] = 8'h10;
    en[3] = 1'b1; base[3] = 8'h30;
    drive_inputs();
    step();
    chk("t4_gnt1", 32'(bus.o_gnt), 32'h2);
    step();
    step();
    chk("t4_drop_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
    step();
    chk("t4_idle_gnt", 32'(bus.o_gnt), 32'h0);
    chk("t4_gid_hold", 32'(bus.o_grant_id), 32'd1);
    chk("t4_pri", 32'(dut.r_pri), 32'd2);
    step();
    chk("t4_gid3", 32'(bus.o_grant_id), 32'd3);
    chk("t4_gnt3", 32'(bus.o_gnt), 32'h8);
    step();
    chk("t4_count", 32'(fq.size()), 32'd3);
    chk("t4_w0", (fq.size() > 0) ? 32'(fq[0]) : 32'hffff_ffff, 32'h10);
    chk("t4_w1", (fq.size() > 1) ? 32'(fq[1]) : 32'hffff_ffff, 32'h11);
    chk("t4_w2", (fq.size() > 2) ? 32'(fq[2]) : 32'hffff_ffff, 32'h30);

    // Test 5: reset pulse in the middle of a burst.
    do_reset();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1; base[i] = 8'(i * 16);
    end
    drive_inputs();
    step();
    chk("t5_din0", 32'(bus.o_fifo_din), 32'h00);
    step();
    chk("t5_din1", 32'(bus.o_fifo_din), 32'h01);
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_wr_en", 32'(bus.o_fifo_wr_en), 32'h0);
    chk("t5_rst_ack", 32'(bus.o_ack), 32'h0);
    chk("t5_rst_din", 32'(bus.o_fifo_din), 32'h0);
    step();
    rst = 1'b0;
    chk("t5_gnt", 32'(bus.o_gnt), 32'h0);
    chk("t5_busy", 32'(bus.o_busy), 32'h0);
    chk("t5_pri", 32'(dut.r_pri), 32'd0);
    chk("t5_count", 32'(fq.size()), 32'd2);
    step();
    chk("t5_regrant", 32'(bus.o_gnt), 32'h1);
    chk("t5_din_after", 32'(bus.o_fifo_din), 32'h02);

    // Test 6: no requests, nothing moves.
    do_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.o_fifo_wr_en !== 1'b0 || bus.o_gnt !== '0 || bus.o_busy !== 1'b0) bad++;
    end
    chk("t6_quiet", 32'(bad), 32'd0);
    chk("t6_empty", 32'(fq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
